// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and the hex/echo front end.
// Timeout support is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_tx_arbiter_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned OWNER_W       = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    // Nibble to upper-case ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after the pointer, with wrap.
module uart_tx_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_valid
);

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!o_valid && i_req[PTR_W'((32'(i_ptr) + k) % NUM_REQ)]) begin
                o_valid  = 1'b1;
                o_winner = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to abort a grant when tx_busy never rises.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic [OWNER_W-1:0]           o_owner,
    output logic                         o_arb_busy,
    output logic                         o_tx_enable,
    output logic [DATA_BITS-1:0]         o_tx_data,
    input  logic                         i_tx_busy,
    output logic                         o_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e            r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]    r_ack;
    logic [OWNER_W-1:0]    r_owner;
    logic                  r_arb_busy;
    logic                  r_tx_enable;
    logic [DATA_BITS-1:0]  r_tx_data;
    logic [PTR_W-1:0]      w_winner;
    logic                  w_valid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
    assign o_err = r_err;
`else
    logic                  w_unused_timeout;
    assign w_unused_timeout = ^32'(BUSY_TIMEOUT);
    assign o_err = 1'b0;
`endif

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Grant / enable-busy handshake / completion sequencing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_ack       <= '0;
            r_owner     <= '0;
            r_arb_busy  <= 1'b0;
            r_tx_enable <= 1'b0;
            r_tx_data   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    // A busy line here belongs to someone else; hold off granting.
                    if (w_valid && !i_tx_busy) begin
                        r_owner     <= OWNER_W'(w_winner);
                        r_tx_data   <= i_req_data[32'(w_winner)*DATA_BITS +: DATA_BITS];
                        r_ptr       <= w_winner;
                        r_tx_enable <= 1'b1;
                        r_arb_busy  <= 1'b1;
                        r_state     <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_tx_enable <= 1'b0;
                        r_state     <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        r_tx_enable <= 1'b0;
                        r_arb_busy  <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_ack      <= NUM_REQ'(1) << r_ptr;
                        r_arb_busy <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_arb_busy  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_owner     = r_owner;
    assign o_arb_busy  = r_arb_busy;
    assign o_tx_enable = r_tx_enable;
    assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;

    typedef struct {
        int unsigned owner;
        logic [7:0]  data;
    } item_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DB-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [2:0]       owner;
    logic             arb_busy;
    logic             tx_enable;
    logic [DB-1:0]    tx_data;
    logic             tx_busy;
    logic             err;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    item_t       pend_q[$];
    item_t       exp_q[$];
    int unsigned m_ptr;
    logic [NR-1:0] drop;
    logic        no_busy;
    logic [7:0]  uart_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .BUSY_TIMEOUT(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_req_data  (req_data),
        .o_ack       (ack),
        .o_owner     (owner),
        .o_arb_busy  (arb_busy),
        .o_tx_enable (tx_enable),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .o_err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart_tx model: busy rises 2 cycles after enable is seen, stays high 20 cycles.
    initial begin
        int dly;
        int left;
        dly = 0;
        left = 0;
        tx_busy = 1'b0;
        uart_data = '0;
        forever begin
            @(negedge clk);
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    left = 20;
                end
            end else if (tx_busy) begin
                left--;
                if (left == 0) tx_busy = 1'b0;
            end else if (tx_enable && !no_busy) begin
                dly = 2;
                uart_data = tx_data;
            end
        end
    end

    // Monitor: checks each completion against the scoreboard.
    initial begin
        logic        prev_en;
        logic        in_xfer;
        logic        stable;
        logic        chain;
        logic [7:0]  g_data;
        int unsigned ack_cyc;
        item_t       e;
        prev_en = 1'b0;
        in_xfer = 1'b0;
        stable  = 1'b1;
        chain   = 1'b0;
        g_data  = '0;
        ack_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
                in_xfer = 1'b0;
                chain   = 1'b0;
                continue;
            end
            if (tx_enable && !prev_en) begin
                g_data  = tx_data;
                stable  = 1'b1;
                in_xfer = 1'b1;
                chk("grant_arb_busy", 32'(arb_busy), 32'd1);
                if (chain) chk("back_to_back_gap", cyc - ack_cyc, 32'd1);
                chain = 1'b0;
            end else if (in_xfer && tx_data !== g_data) begin
                stable = 1'b0;
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'd1 << e.owner);
                    chk("ack_owner", 32'(owner), e.owner);
                    chk("granted_data", 32'(g_data), 32'(e.data));
                    chk("uart_data", 32'(uart_data), 32'(e.data));
                    chk("data_stable", 32'(stable), 32'd1);
                    chk("ack_arb_idle", 32'(arb_busy), 32'd0);
`ifndef UART_ARB_TIMEOUT_EN
                    chk("err_tied_low", 32'(err), 32'd0);
`endif
                end
                in_xfer = 1'b0;
                ack_cyc = cyc;
                chain   = (exp_q.size() != 0);
            end
            prev_en = tx_enable;
        end
    end

    task automatic add(input int unsigned i, input logic [7:0] d);
        item_t it;
        it.owner = i;
        it.data  = d;
        pend_q.push_back(it);
    endtask

    // Requester i presents its oldest pending byte.
    task automatic refresh();
        logic [NR-1:0]    r;
        logic [NR*DB-1:0] d;
        r = '0;
        d = '0;
        for (int j = pend_q.size() - 1; j >= 0; j--) begin
            r[pend_q[j].owner] = 1'b1;
            d[pend_q[j].owner*DB +: DB] = pend_q[j].data;
        end
        req      = r & ~drop;
        req_data = d;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (ack[i]) begin
                for (int j = 0; j < pend_q.size(); j++) begin
                    if (pend_q[j].owner == i) begin
                        pend_q.delete(j);
                        break;
                    end
                end
            end
        end
        refresh();
    endtask

    // Reference: serve pending bytes in round-robin order of requesters.
    task automatic plan();
        item_t work[$];
        bit    found;
        int unsigned c;
        work = pend_q;
        while (work.size() > 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR && !found; k++) begin
                c = (m_ptr + k) % NR;
                for (int j = 0; j < work.size() && !found; j++) begin
                    if (work[j].owner == c) begin
                        exp_q.push_back(work[j]);
                        work.delete(j);
                        m_ptr = c;
                        found = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic run_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || pend_q.size() != 0 || arb_busy) && n < budget);
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_en(input string name);
        int n;
        n = 0;
        while (!tx_enable && n < 50) begin
            step();
            n++;
        end
        chk(name, 32'(tx_enable), 32'd1);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        drop     = '0;
        no_busy  = 1'b0;
        m_ptr    = NR - 1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single requester: enable one cycle after grant, byte 8'h41.
        add(0, 8'h41);
        plan();
        step();
        @(posedge clk);
        #1;
        chk("t1_tx_enable", 32'(tx_enable), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'h41);
        chk("t1_owner", 32'(owner), 32'd0);
        chk("t1_arb_busy", 32'(arb_busy), 32'd1);
        run_idle("t1_drain", 200);
        chk("t1_idle", 32'(arb_busy), 32'd0);

        // Lone requester 2 wins three rounds in a row.
        for (int k = 0; k < 3; k++) add(2, 8'h5A);
        plan();
        run_idle("t3_drain", 300);

        // Requester 1 drops req while waiting for busy; byte still completes.
        add(1, 8'hC3);
        plan();
        step();
        wait_en("t5_grant");
        drop[1] = 1'b1;
        run_idle("t5_drain", 200);
        drop = '0;

        // Reset in WAIT_DONE abandons the byte without an ack.
        add(2, 8'h77);
        step();
        n = 0;
        while (!(arb_busy && !tx_enable && tx_busy) && n < 100) begin
            step();
            n++;
        end
        chk("t4_reach_wait_done", 32'(n < 100), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("t4_rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("t4_rst_ack", 32'(ack), 32'd0);
        pend_q.delete();
        m_ptr = NR - 1;
        refresh();
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (tx_busy && n < 100) begin
            step();
            n++;
        end
        chk("t4_line_free", 32'(tx_busy), 32'd0);

        // All four requesting after reset: order 0,1,2,3,0.
        for (int i = 0; i < NR; i++) add(i, 8'(8'h30 + i));
        add(0, 8'h34);
        plan();
        run_idle("t2_drain", 400);

        // Randomized request mixes.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NR; i++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) add(i, 8'($urandom));
            end
            plan();
            run_idle("rand_drain", 2000);
        end

`ifdef UART_ARB_TIMEOUT_EN
        // Busy never rises: err after BUSY_TIMEOUT cycles, pointer still advances.
        begin
            int unsigned en_c;
            no_busy = 1'b1;
            add(3, 8'hAA);
            step();
            wait_en("to_grant");
            en_c = cyc;
            n = 0;
            while (!err && n < 200) begin
                step();
                n++;
            end
            chk("to_err_pulse", 32'(err), 32'd1);
            chk("to_err_latency", cyc - en_c, 32'd64);
            chk("to_no_enable", 32'(tx_enable), 32'd0);
            pend_q.delete();
            refresh();
            m_ptr = 3;
            no_busy = 1'b0;
            step();
            chk("to_err_one_cycle", 32'(err), 32'd0);
            add(3, 8'h13);
            add(0, 8'h10);
            plan();
            run_idle("to_after_drain", 400);
        end
`endif

        repeat (3) step();
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
